// File: rtl/seq_pkg.sv
// Shared constants for the instruction sequencer: state codes, special
// instruction words, fault codes and the sequential PC increment.
package seq_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_TIMEOUT  = 2'd1;
    localparam logic [1:0] FC_ILLEGAL  = 2'd2;
    localparam logic [1:0] FC_MISALIGN = 2'd3;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/seq_timeout.sv
// Loadable 8-bit down-counter; expire_o flags the decrement that would
// take the count from 1 to 0, i.e. the last permitted wait cycle.
module seq_timeout (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic       expire_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    assign expire_o = dec_i && !load_i && (cnt_q == 8'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control unit: owns PC/IR, fetches from variable-latency
// instruction memory, pulses reg_we once per instruction, halts and faults.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             clear_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_valid_i,
    input  logic [31:0]      imem_rdata_i,
    input  logic             jump_valid_i,
    input  logic [31:0]      jump_target_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ir_o,
    output logic             reg_we_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [1:0]       fault_code_o,
    output logic [CNT_W-1:0] retired_o
);
    import seq_pkg::*;

    logic [2:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [1:0]       code_q, code_d;
    logic             single_q, single_d;
    logic             req_q, we_q, halted_q, fault_q;
    logic             tmr_load, tmr_dec, tmr_expire;
    logic             jump_bad;

    assign jump_bad = jump_valid_i && (jump_target_i[1:0] != 2'b00);

    seq_timeout u_timeout (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (8'(TIMEOUT)),
        .dec_i      (tmr_dec),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ret_d    = ret_q;
        code_d   = code_q;
        single_d = single_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d  = S_FETCH;
                    single_d = 1'b0;
                end else if (step_i) begin
                    state_d  = S_FETCH;
                    single_d = 1'b1;
                end
            end
            S_FETCH: begin
                tmr_load = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // data arriving on the last allowed cycle still wins over the timeout
                if (imem_valid_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = S_EXEC;
                end else begin
                    tmr_dec = 1'b1;
                    if (tmr_expire) begin
                        state_d = S_FAULT;
                        code_d  = FC_TIMEOUT;
                    end
                end
            end
            S_EXEC: begin
                if (ir_q == EBREAK_INSTR) begin
                    state_d = S_HALT;
                end else if (ir_q[1:0] != 2'b11) begin
                    state_d = S_FAULT;
                    code_d  = FC_ILLEGAL;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (jump_bad) begin
                    state_d = S_FAULT;
                    code_d  = FC_MISALIGN;
                end else begin
                    pc_d    = jump_valid_i ? jump_target_i : pc_q + PC_STEP;
                    ret_d   = ret_q + CNT_W'(1);
                    state_d = (run_i && !single_q) ? S_FETCH : S_IDLE;
                end
            end
            S_HALT, S_FAULT: begin
                if (clear_i) begin
                    state_d = S_IDLE;
                    code_d  = FC_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= NOP_INSTR;
            ret_q    <= '0;
            code_q   <= FC_NONE;
            single_q <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ret_q    <= ret_d;
            code_q   <= code_d;
            single_q <= single_d;
            req_q    <= (state_d == S_FETCH);
            we_q     <= (state_d == S_WB);
            halted_q <= (state_d == S_HALT);
            fault_q  <= (state_d == S_FAULT);
        end
    end

    // The write pulse is registered on entry to WB; a misaligned jump seen
    // during WB must still suppress it in the same cycle.
    assign reg_we_o     = we_q && !jump_bad;
    assign imem_req_o   = req_q;
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign ir_o         = ir_q;
    assign busy_o       = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                          (state_q == S_EXEC)  || (state_q == S_WB);
    assign halted_o     = halted_q;
    assign fault_o      = fault_q;
    assign fault_code_o = code_q;
    assign retired_o    = ret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed + randomized bench for instr_sequencer; expected PC, IR and
// retired count come from a per-instruction reference model.
module tb_instr_sequencer;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, run, step, clear, imem_valid, jump_valid;
    logic [31:0] imem_rdata, jump_target;
    logic        imem_req, reg_we, busy, halted, fault;
    logic [31:0] imem_addr, pc, ir, retired;
    logic [1:0]  fault_code;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_pc, m_ir, m_ret;

    instr_sequencer #(.RESET_PC(32'h0), .TIMEOUT(4), .CNT_W(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .run_i        (run),
        .step_i       (step),
        .clear_i      (clear),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_valid_i (imem_valid),
        .imem_rdata_i (imem_rdata),
        .jump_valid_i (jump_valid),
        .jump_target_i(jump_target),
        .pc_o         (pc),
        .ir_o         (ir),
        .reg_we_o     (reg_we),
        .busy_o       (busy),
        .halted_o     (halted),
        .fault_o      (fault),
        .fault_code_o (fault_code),
        .retired_o    (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addi_word();
        logic [31:0] w;
        w = $urandom();
        return {w[31:7], 7'b0010011};
    endfunction

    // Leave IDLE by run (stays running) or by a one-cycle step pulse.
    task automatic go_fetch(input bit use_step);
        if (use_step) step = 1'b1; else run = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic do_clear(input bit with_run);
        clear = 1'b1;
        run   = with_run;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_halted", 64'(halted), 64'(1'b0));
        chk("clr_fault", 64'(fault), 64'(1'b0));
        chk("clr_code", 64'(fault_code), 64'(2'd0));
        chk("clr_busy", 64'(busy), 64'(1'b0));
        chk("clr_pc", 64'(pc), 64'(m_pc));
    endtask

    // Entry: at a negedge with the DUT in FETCH. lat = empty WAIT cycles.
    task automatic do_instr(input logic [31:0] word, input int lat, input bit jv,
                            input logic [31:0] jt, input bit run_wb);
        bit bad;
        chk("fetch_req", 64'(imem_req), 64'(1'b1));
        chk("fetch_addr", 64'(imem_addr), 64'(m_pc));
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            chk("wait_busy", 64'(busy), 64'(1'b1));
            chk("wait_req", 64'(imem_req), 64'(1'b0));
            imem_valid = (k == lat);
            imem_rdata = (k == lat) ? word : $urandom();
        end
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = $urandom();
        m_ir = word;
        chk("exec_ir", 64'(ir), 64'(word));
        chk("exec_we", 64'(reg_we), 64'(1'b0));
        if (word == EBREAK) begin
            @(negedge clk);
            chk("halt_halted", 64'(halted), 64'(1'b1));
            chk("halt_we", 64'(reg_we), 64'(1'b0));
            chk("halt_pc", 64'(pc), 64'(m_pc));
            chk("halt_busy", 64'(busy), 64'(1'b0));
            return;
        end
        if (word[1:0] != 2'b11) begin
            @(negedge clk);
            chk("ill_fault", 64'(fault), 64'(1'b1));
            chk("ill_code", 64'(fault_code), 64'(2'd2));
            chk("ill_pc", 64'(pc), 64'(m_pc));
            return;
        end
        jump_valid  = jv;
        jump_target = jt;
        run         = run_wb;
        bad         = jv && (jt[1:0] != 2'b00);
        @(negedge clk);
        chk("wb_we", 64'(reg_we), 64'(!bad));
        @(negedge clk);
        jump_valid = 1'b0;
        if (bad) begin
            chk("mis_fault", 64'(fault), 64'(1'b1));
            chk("mis_code", 64'(fault_code), 64'(2'd3));
            chk("mis_pc", 64'(pc), 64'(m_pc));
            chk("mis_retired", 64'(retired), 64'(m_ret));
        end else begin
            m_pc  = jv ? jt : m_pc + 32'd4;
            m_ret = m_ret + 32'd1;
            chk("next_pc", 64'(pc), 64'(m_pc));
            chk("next_retired", 64'(retired), 64'(m_ret));
            chk("next_req", 64'(imem_req), 64'(run_wb));
            chk("next_busy", 64'(busy), 64'(run_wb));
        end
    endtask

    initial begin
        logic [31:0] t;
        bit          jv;
        rst_n = 1'b0; run = 1'b0; step = 1'b0; clear = 1'b0;
        imem_valid = 1'b0; imem_rdata = '0; jump_valid = 1'b0; jump_target = '0;
        m_pc = 32'h0; m_ir = NOP; m_ret = 32'h0;

        // reset state
        @(negedge clk);
        chk("rst_pc", 64'(pc), 64'(32'h0));
        chk("rst_ir", 64'(ir), 64'(NOP));
        chk("rst_req", 64'(imem_req), 64'(1'b0));
        chk("rst_we", 64'(reg_we), 64'(1'b0));
        chk("rst_halted", 64'(halted), 64'(1'b0));
        chk("rst_fault", 64'(fault), 64'(1'b0));
        chk("rst_code", 64'(fault_code), 64'(2'd0));
        chk("rst_retired", 64'(retired), 64'(32'h0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);

        // free run, zero-wait memory, three instructions
        go_fetch(1'b0);
        for (int i = 0; i < 3; i++) do_instr(addi_word(), 0, 1'b0, 32'h0, 1'b1);
        chk("run3_retired", 64'(retired), 64'(32'd3));

        // randomized latencies and aligned jumps; run drops during the last one
        for (int i = 0; i < 10; i++) begin
            t  = $urandom();
            jv = ($urandom_range(3) == 0);
            do_instr(addi_word(), int'($urandom_range(3)), jv, {t[31:2], 2'b00}, i != 9);
        end
        @(negedge clk);
        chk("stop_idle", 64'(busy), 64'(1'b0));

        // single step with 3 empty wait cycles, then a second step
        go_fetch(1'b1);
        do_instr(addi_word(), 3, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("step_stays_idle", 64'(imem_req), 64'(1'b0));
        go_fetch(1'b1);
        do_instr(addi_word(), 0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);

        // jumps: aligned, to top of address space (wrap), then misaligned
        go_fetch(1'b0);
        do_instr(addi_word(), 0, 1'b1, 32'h40, 1'b1);
        do_instr(addi_word(), 1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        do_instr(addi_word(), 0, 1'b0, 32'h0, 1'b1);
        chk("wrap_pc", 64'(pc), 64'(32'h0));
        do_instr(addi_word(), 0, 1'b1, 32'h42, 1'b1);
        imem_valid = 1'b1;
        imem_rdata = $urandom();
        @(negedge clk);
        imem_valid = 1'b0;
        chk("fault_sticky", 64'(fault), 64'(1'b1));
        chk("fault_ir_kept", 64'(ir), 64'(m_ir));
        do_clear(1'b0);
        @(negedge clk);

        // EBREAK halts; clear+run together go IDLE, then FETCH at same pc
        go_fetch(1'b0);
        do_instr(EBREAK, 2, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("halt_sticky", 64'(halted), 64'(1'b1));
        do_clear(1'b1);
        chk("clr_req", 64'(imem_req), 64'(1'b0));
        @(negedge clk);
        do_instr(addi_word(), 0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);

        // fetch timeout: 4 WAIT cycles then FAULT code 1
        go_fetch(1'b1);
        chk("to_req", 64'(imem_req), 64'(1'b1));
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            chk("to_waiting", 64'(fault), 64'(1'b0));
        end
        @(negedge clk);
        chk("to_fault", 64'(fault), 64'(1'b1));
        chk("to_code", 64'(fault_code), 64'(2'd1));
        chk("to_ir", 64'(ir), 64'(m_ir));
        do_clear(1'b0);

        // illegal opcode
        go_fetch(1'b1);
        do_instr(32'h0000_0000, 1, 1'b0, 32'h0, 1'b0);
        do_clear(1'b0);

        // reset during WAIT; late valid must be ignored
        go_fetch(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        m_pc = 32'h0; m_ir = NOP; m_ret = 32'h0;
        chk("mid_rst_pc", 64'(pc), 64'(m_pc));
        chk("mid_rst_ir", 64'(ir), 64'(m_ir));
        chk("mid_rst_req", 64'(imem_req), 64'(1'b0));
        chk("mid_rst_retired", 64'(retired), 64'(m_ret));
        chk("mid_rst_busy", 64'(busy), 64'(1'b0));
        @(negedge clk);
        rst_n      = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = addi_word();
        @(negedge clk);
        imem_valid = 1'b0;
        chk("late_valid_ir", 64'(ir), 64'(NOP));
        chk("late_valid_busy", 64'(busy), 64'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control unit that owns the program counter and instruction register for the single-cycle datapath (decoder, regfile, ALU).
- Fetches each instruction from an instruction memory with variable read latency.
- Holds the instruction stable while the datapath evaluates it, then issues one register write-enable pulse and advances the PC.
- Supports free-run, single-step, halt-on-EBREAK and fault reporting, so the core can be run from a board button or a bench.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 255, maximum WAIT cycles before fetch-timeout fault (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  level; 1 = execute continuously
step  in  1  one-cycle pulse; execute exactly one instruction from IDLE
clear  in  1  one-cycle pulse; leave HALT/FAULT back to IDLE
imem_req  out  1  one-cycle fetch request
imem_addr  out  32  fetch address (equals pc)
imem_valid  in  1  read data valid; sampled only in WAIT
imem_rdata  in  32  instruction word
jump_valid  in  1  datapath requests non-sequential PC (sampled in WB)
jump_target  in  32  new PC when jump_valid
pc  out  32  current PC, to datapath ALU mux
ir  out  32  instruction register, to decoder
reg_we  out  1  regfile write enable, one cycle per instruction
busy  out  1  1 in FETCH/WAIT/EXEC/WB
halted  out  1  1 in HALT
fault  out  1  1 in FAULT
fault_code  out  2  1=fetch timeout, 2=illegal opcode, 3=misaligned jump
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, ir=32'h0000_0013 (NOP), imem_req=0, reg_we=0, halted=0, fault=0, fault_code=0, retired=0, wait timer=0, single-step flag=0. Reset mid-instruction aborts it with no write.
- States: IDLE, FETCH, WAIT, EXEC, WB, HALT, FAULT.
- IDLE:
  - run=1 -> FETCH with single=0.
  - Else step=1 -> FETCH with single=1.
- FETCH: imem_req=1, imem_addr=pc for exactly this cycle; timer cleared -> WAIT.
- WAIT:
  - imem_valid=1 -> ir<=imem_rdata, -> EXEC.
  - Else timer++; when timer reaches TIMEOUT -> FAULT, code 1, ir unchanged.
  - Minimum fetch latency: FETCH->WAIT->EXEC, data accepted in the first WAIT cycle at the earliest.
- EXEC: one cycle, datapath settles on ir.
  - ir==32'h0010_0073 (EBREAK) -> HALT, no write, pc unchanged.
  - ir[1:0]!=2'b11 -> FAULT, code 2.
  - Otherwise -> WB.
- WB: reg_we=1.
  - If jump_valid and jump_target[1:0]!=0 -> FAULT, code 3, reg_we forced 0, pc unchanged.
  - Else pc <= jump_valid ? jump_target : pc+4 (32-bit wrap at 32'hFFFF_FFFC -> 0), retired++ (wraps).
  - Next state: FETCH if run=1 and single=0, else IDLE.
- Minimum instruction period: 4 cycles (FETCH, WAIT, EXEC, WB) with 0-wait memory.
- HALT/FAULT: sticky; halted/fault held. clear=1 -> IDLE, fault_code<=0, pc kept. run/step ignored here.
- Simultaneous events:
  - clear with run in HALT: clear wins (-> IDLE); run acts the next cycle.
  - step while running or mid-instruction: ignored.
  - run deasserted mid-instruction: the current instruction completes through WB, then IDLE.
  - imem_valid outside WAIT: ignored.
  - clear outside HALT/FAULT: ignored.
- All outputs registered except imem_addr (=pc) and busy (state decode).

Decomposition:
- Package seq_pkg:
  - state enum
  - NOP_INSTR, EBREAK_INSTR constants
  - fault code constants
  - PC_STEP=4
- One sub-module, seq_timeout: loadable 8-bit down-counter with expire flag, used for the WAIT timer.
- Everything else is inline FSM plus PC/IR/retired registers.

Test Plan:
- Reset then run=1, 0-wait memory returning ADDI words at pc 0,4,8 -> imem_req every 4 cycles, addresses 0,4,8, one reg_we per instruction, retired=3 after 12 cycles.
- run=0, single step pulse, memory valid after 3 WAIT cycles -> one fetch at pc=0, reg_we once, returns to IDLE, pc=4, retired=1; second step gives pc=8.
- jump_valid=1, jump_target=32'h40 in WB -> next imem_addr=32'h40. Repeat with target 32'h42 -> FAULT, fault_code=3, reg_we=0, pc unchanged, retired not incremented.
- imem_rdata=32'h0010_0073 -> HALT, halted=1, no reg_we. clear and run asserted together -> IDLE, then FETCH the next cycle at the same pc.
- imem_valid never asserted, TIMEOUT=4 -> FAULT with code 1 exactly 4 WAIT cycles after FETCH. Word 32'h0000_0000 -> FAULT with code 2.
- rst pulsed low during WAIT -> immediately pc=RESET_PC, ir=NOP, imem_req=0, retired=0, state IDLE; a late imem_valid is ignored.
